// File: rtl/sme_char_loader.sv
// Input stage of the string-matching engine: frames the serial character stream into
// string and pattern buffers and hands one job per pattern to the matcher.
module sme_char_loader #(
  parameter int unsigned DW        = 8,
  parameter int unsigned STR_DEPTH = 32,
  parameter int unsigned PAT_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DW-1:0]                  chardata,
  input  logic                           isstring,
  input  logic                           ispattern,
  output logic                           in_busy,
  output logic                           job_valid,
  input  logic                           job_ready,
  output logic [$clog2(STR_DEPTH):0]     str_len,
  output logic [$clog2(PAT_DEPTH):0]     pat_len,
  input  logic [$clog2(STR_DEPTH)-1:0]   str_raddr,
  output logic [DW-1:0]                  str_rdata,
  input  logic [$clog2(PAT_DEPTH)-1:0]   pat_raddr,
  output logic [DW-1:0]                  pat_rdata,
  output logic                           ovf_err
);

  localparam int unsigned SAW = $clog2(STR_DEPTH);
  localparam int unsigned SLW = SAW + 1;
  localparam int unsigned PAW = $clog2(PAT_DEPTH);
  localparam int unsigned PLW = PAW + 1;

  typedef enum logic [1:0] {IDLE, LOAD_S, LOAD_P, READY} state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   str_mem [STR_DEPTH];
  logic [DW-1:0]   pat_mem [PAT_DEPTH];

  logic            str_we, pat_we, ovf_set;
  logic [SAW-1:0]  str_wa;
  logic [PAW-1:0]  pat_wa;
  logic [SLW-1:0]  str_len_nxt;
  logic [PLW-1:0]  pat_len_nxt;
  logic            str_full, pat_full;

  assign str_full = (str_len == SLW'(STR_DEPTH));
  assign pat_full = (pat_len == PLW'(PAT_DEPTH));

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      str_len   <= '0;
      pat_len   <= '0;
      ovf_err   <= 1'b0;
      in_busy   <= 1'b0;
      job_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      str_len   <= str_len_nxt;
      pat_len   <= pat_len_nxt;
      ovf_err   <= ovf_err | ovf_set;
      in_busy   <= (state_nxt == READY);
      job_valid <= (state_nxt == READY);
    end
  end

  // Next-state logic; isstring wins when both flags are high
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (isstring)       state_nxt = LOAD_S;
        else if (ispattern) state_nxt = LOAD_P;
      end
      LOAD_S: begin
        if (isstring)       state_nxt = LOAD_S;
        else if (ispattern) state_nxt = LOAD_P;
        else                state_nxt = IDLE;
      end
      LOAD_P: begin
        if (ispattern && !isstring) state_nxt = LOAD_P;
        else                        state_nxt = READY;
      end
      READY: begin
        if (job_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Buffer writes, length updates and overflow detection
  always_comb begin
    str_we      = 1'b0;
    pat_we      = 1'b0;
    ovf_set     = 1'b0;
    str_wa      = str_len[SAW-1:0];
    pat_wa      = pat_len[PAW-1:0];
    str_len_nxt = str_len;
    pat_len_nxt = pat_len;
    case (state)
      IDLE: begin
        if (isstring) begin
          str_we      = 1'b1;
          str_wa      = '0;
          str_len_nxt = SLW'(1);
          pat_len_nxt = '0;
          ovf_set     = ispattern;
        end else if (ispattern) begin
          pat_we      = 1'b1;
          pat_wa      = '0;
          pat_len_nxt = PLW'(1);
        end
      end
      LOAD_S: begin
        if (isstring) begin
          ovf_set = ispattern;
          if (str_full) begin
            ovf_set = 1'b1;
          end else begin
            str_we      = 1'b1;
            str_len_nxt = str_len + SLW'(1);
          end
        end else if (ispattern) begin
          pat_we      = 1'b1;
          pat_wa      = '0;
          pat_len_nxt = PLW'(1);
        end
      end
      LOAD_P: begin
        if (isstring) begin
          ovf_set = 1'b1;
        end else if (ispattern) begin
          if (pat_full) begin
            ovf_set = 1'b1;
          end else begin
            pat_we      = 1'b1;
            pat_len_nxt = pat_len + PLW'(1);
          end
        end
      end
      READY: begin
        ovf_set = isstring | ispattern;
      end
      default: ;
    endcase
  end

  // Buffer storage is deliberately left unreset
  always_ff @(posedge clk) begin
    if (!reset && str_we) str_mem[str_wa] <= chardata;
    if (!reset && pat_we) pat_mem[pat_wa] <= chardata;
  end

  assign str_rdata = (SLW'(str_raddr) < str_len) ? str_mem[str_raddr] : '0;
  assign pat_rdata = (PLW'(pat_raddr) < pat_len) ? pat_mem[pat_raddr] : '0;

endmodule

// File: tb/tb_sme_char_loader.sv
// Directed, table-driven bench for sme_char_loader with hand-written overflow sequence.
module tb_sme_char_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] chardata = '0;
  logic       isstring = 1'b0, ispattern = 1'b0, job_ready = 1'b0;
  logic [4:0] str_raddr = '0;
  logic [2:0] pat_raddr = '0;
  logic       in_busy, job_valid, ovf_err;
  logic [5:0] str_len;
  logic [3:0] pat_len;
  logic [7:0] str_rdata, pat_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sme_char_loader dut (
    .clk(clk), .reset(reset), .chardata(chardata), .isstring(isstring),
    .ispattern(ispattern), .in_busy(in_busy), .job_valid(job_valid),
    .job_ready(job_ready), .str_len(str_len), .pat_len(pat_len),
    .str_raddr(str_raddr), .str_rdata(str_rdata), .pat_raddr(pat_raddr),
    .pat_rdata(pat_rdata), .ovf_err(ovf_err)
  );

  typedef struct {
    logic       rst, s, p;
    logic [7:0] ch;
    logic       rdy;
    logic [4:0] sra;
    logic [2:0] pra;
    logic       busy, jv;
    logic [5:0] sl;
    logic [3:0] pl;
    logic [7:0] srd, prd;
    logic       ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, s, p, input logic [7:0] ch, input logic rdy,
                     input logic [4:0] sra, input logic [2:0] pra,
                     input logic busy, jv, input logic [5:0] sl, input logic [3:0] pl,
                     input logic [7:0] srd, prd, input logic ovf);
    vec_t v;
    v.rst = rst; v.s = s; v.p = p; v.ch = ch; v.rdy = rdy; v.sra = sra; v.pra = pra;
    v.busy = busy; v.jv = jv; v.sl = sl; v.pl = pl; v.srd = srd; v.prd = prd; v.ovf = ovf;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic rst, s, p, input logic [7:0] ch, input logic rdy,
                      input logic [4:0] sra, input logic [2:0] pra);
    @(negedge clk);
    reset = rst; isstring = s; ispattern = p; chardata = ch; job_ready = rdy;
    str_raddr = sra; pat_raddr = pra;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = tbl[i];
    step(v.rst, v.s, v.p, v.ch, v.rdy, v.sra, v.pra);
    check("in_busy",   i, 32'(in_busy),   32'(v.busy));
    check("job_valid", i, 32'(job_valid), 32'(v.jv));
    check("str_len",   i, 32'(str_len),   32'(v.sl));
    check("pat_len",   i, 32'(pat_len),   32'(v.pl));
    check("str_rdata", i, 32'(str_rdata), 32'(v.srd));
    check("pat_rdata", i, 32'(pat_rdata), 32'(v.prd));
    check("ovf_err",   i, 32'(ovf_err),   32'(v.ovf));
  endtask

  localparam int SPLIT = 16;

  initial begin
    //   rst s p ch     rdy sra pra  busy jv sl  pl srd    prd    ovf
    add(1, 0, 0, 8'h00, 0, 0, 0,   0, 0, 0, 0, 8'h00, 8'h00, 0); // reset state
    add(0, 1, 0, 8'h41, 0, 0, 0,   0, 0, 1, 0, 8'h41, 8'h00, 0); // "ABCD"
    add(0, 1, 0, 8'h42, 0, 0, 0,   0, 0, 2, 0, 8'h41, 8'h00, 0);
    add(0, 1, 0, 8'h43, 0, 0, 0,   0, 0, 3, 0, 8'h41, 8'h00, 0);
    add(0, 1, 0, 8'h44, 0, 0, 0,   0, 0, 4, 0, 8'h41, 8'h00, 0);
    add(0, 0, 1, 8'h42, 0, 0, 0,   0, 0, 4, 1, 8'h41, 8'h42, 0); // "BC"
    add(0, 0, 1, 8'h43, 0, 0, 0,   0, 0, 4, 2, 8'h41, 8'h42, 0); // cycle N
    add(0, 0, 0, 8'h00, 0, 0, 0,   1, 1, 4, 2, 8'h41, 8'h42, 0); // valid from N+2
    add(0, 0, 0, 8'h00, 0, 2, 0,   1, 1, 4, 2, 8'h43, 8'h42, 0);
    add(0, 0, 0, 8'h00, 0, 0, 5,   1, 1, 4, 2, 8'h41, 8'h00, 0);
    add(0, 0, 0, 8'h00, 0, 3, 1,   1, 1, 4, 2, 8'h44, 8'h43, 0);
    add(0, 0, 0, 8'h00, 0, 0, 0,   1, 1, 4, 2, 8'h41, 8'h42, 0);
    add(0, 0, 0, 8'h00, 1, 0, 0,   0, 0, 4, 2, 8'h41, 8'h42, 0); // accept
    add(0, 0, 1, 8'h44, 0, 3, 0,   0, 0, 4, 1, 8'h44, 8'h44, 0); // pattern-only "D"
    add(0, 0, 0, 8'h00, 0, 3, 1,   1, 1, 4, 1, 8'h44, 8'h00, 0);
    add(0, 0, 0, 8'h00, 1, 0, 0,   0, 0, 4, 1, 8'h41, 8'h44, 0);
    // SPLIT: chars dropped in READY and on a both-flags cycle
    add(1, 0, 0, 8'h00, 0, 0, 0,   0, 0, 0, 0, 8'h00, 8'h00, 0);
    add(0, 1, 0, 8'h58, 0, 0, 0,   0, 0, 1, 0, 8'h58, 8'h00, 0);
    add(0, 0, 1, 8'h5A, 0, 0, 0,   0, 0, 1, 1, 8'h58, 8'h5A, 0);
    add(0, 0, 0, 8'h00, 0, 0, 0,   1, 1, 1, 1, 8'h58, 8'h5A, 0);
    add(0, 1, 0, 8'h51, 0, 0, 0,   1, 1, 1, 1, 8'h58, 8'h5A, 1);
    add(0, 0, 1, 8'h52, 0, 0, 0,   1, 1, 1, 1, 8'h58, 8'h5A, 1);
    add(0, 1, 1, 8'h53, 0, 0, 0,   1, 1, 1, 1, 8'h58, 8'h5A, 1);
    add(0, 0, 0, 8'h00, 1, 0, 0,   0, 0, 1, 1, 8'h58, 8'h5A, 1);
    add(1, 0, 0, 8'h00, 0, 0, 0,   0, 0, 0, 0, 8'h00, 8'h00, 0);
    add(0, 1, 0, 8'h58, 0, 0, 0,   0, 0, 1, 0, 8'h58, 8'h00, 0);
    add(0, 0, 1, 8'h5A, 0, 0, 0,   0, 0, 1, 1, 8'h58, 8'h5A, 0);
    add(0, 1, 1, 8'h53, 0, 0, 1,   1, 1, 1, 1, 8'h58, 8'h00, 1); // both flags in LOAD_P
    add(0, 0, 0, 8'h00, 1, 0, 0,   0, 0, 1, 1, 8'h58, 8'h5A, 1);
    add(0, 1, 1, 8'h61, 0, 0, 0,   0, 0, 1, 0, 8'h61, 8'h00, 1); // both flags in IDLE
    // reset mid-load, then pattern-only job with empty string
    add(1, 0, 0, 8'h00, 0, 0, 0,   0, 0, 0, 0, 8'h00, 8'h00, 0);
    add(0, 1, 0, 8'h41, 0, 0, 0,   0, 0, 1, 0, 8'h41, 8'h00, 0);
    add(0, 1, 0, 8'h42, 0, 0, 0,   0, 0, 2, 0, 8'h41, 8'h00, 0);
    add(1, 1, 0, 8'h43, 0, 0, 0,   0, 0, 0, 0, 8'h00, 8'h00, 0);
    add(0, 0, 1, 8'h4B, 0, 0, 0,   0, 0, 0, 1, 8'h00, 8'h4B, 0);
    add(0, 0, 0, 8'h00, 0, 0, 0,   1, 1, 0, 1, 8'h00, 8'h4B, 0);
    add(0, 0, 0, 8'h00, 1, 0, 0,   0, 0, 0, 1, 8'h00, 8'h4B, 0);
    // string abandoned without a pattern issues no job
    add(0, 1, 0, 8'h41, 0, 0, 0,   0, 0, 1, 0, 8'h41, 8'h00, 0);
    add(0, 0, 0, 8'h00, 0, 0, 0,   0, 0, 1, 0, 8'h41, 8'h00, 0);
    add(0, 0, 0, 8'h00, 0, 0, 0,   0, 0, 1, 0, 8'h41, 8'h00, 0);

    for (int i = 0; i < SPLIT; i++) run_vec(i);

    // 40 string chars then 10 pattern chars: both buffers saturate
    for (int i = 0; i < 40; i++) step(0, 1, 0, 8'(8'h60 + i), 0, 5'd31, 3'd7);
    check("ovf_str_len",   100, 32'(str_len),   32'd32);
    check("ovf_str_err",   100, 32'(ovf_err),   32'd1);
    check("ovf_str_last",  100, 32'(str_rdata), 32'h7F);
    check("ovf_str_plen",  100, 32'(pat_len),   32'd0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 8'(8'h30 + i), 0, 5'd0, 3'd7);
    check("ovf_pat_len",   101, 32'(pat_len),   32'd8);
    check("ovf_pat_last",  101, 32'(pat_rdata), 32'h37);
    check("ovf_str_first", 101, 32'(str_rdata), 32'h60);
    step(0, 0, 0, 8'h00, 0, 5'd0, 3'd0);
    check("ovf_job_valid", 102, 32'(job_valid), 32'd1);
    check("ovf_keep_slen", 102, 32'(str_len),   32'd32);
    step(0, 0, 0, 8'h00, 1, 5'd0, 3'd0);
    check("ovf_accept",    103, 32'(job_valid), 32'd0);
    check("ovf_sticky",    103, 32'(ovf_err),   32'd1);

    for (int i = SPLIT; i < tbl.size(); i++) run_vec(i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
